// File: rtl/alt_run_scheduler_if.sv
// Channel-side bit handshake and channel-tagged detection event stream of alt_run_scheduler.
// The slave modport is the scheduler side, and the master modport is the front-end/consumer side.
interface alt_run_scheduler_if #(
    parameter int NCH = 4,
    parameter int CW  = 4
);
    localparam int CHW = $clog2(NCH);

    logic [NCH-1:0] ch_valid;
    logic [NCH-1:0] ch_bit;
    logic [NCH-1:0] ch_ready;
    logic           det_valid;
    logic [CHW-1:0] det_ch;
    logic [CW-1:0]  det_run;
    logic           det_ready;

    modport master (
        output ch_valid, ch_bit, det_ready,
        input  ch_ready, det_valid, det_ch, det_run
    );

    modport slave (
        input  ch_valid, ch_bit, det_ready,
        output ch_ready, det_valid, det_ch, det_run
    );
endinterface

// File: rtl/alt_run_scheduler.sv
// Round-robin time-shared alternating-bit run detector over NCH serial channels.
// Each channel keeps its own context, and every detection is emitted as a channel-tagged event.
module alt_run_scheduler #(
    parameter int NCH     = 4,
    parameter int MIN_RUN = 3,
    parameter int CW      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic flush,
    output logic busy,
    alt_run_scheduler_if.slave bus
);
    localparam int PW = $clog2(NCH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [CW-1:0] RUN_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] RUN_FIRE = CW'(MIN_RUN);
    localparam logic [PW-1:0] LAST_CH  = PW'(NCH - 1);

    logic [1:0]    state_reg, state_next;
    logic [PW-1:0] rr_ptr_reg;
    logic          has_reg  [NCH];
    logic          last_reg [NCH];
    logic [CW-1:0] run_reg  [NCH];
    logic [CW-1:0] run_next [NCH];

    logic          det_valid_reg;
    logic [PW-1:0] det_ch_reg;
    logic [CW-1:0] det_run_reg;

    logic           stall;
    logic           accept;
    logic [NCH-1:0] grant_vec;
    logic [PW-1:0]  grant_idx;
    logic [CW-1:0]  grant_run;
    logic           fire;

    assign stall = det_valid_reg & ~bus.det_ready;

    // Search the channels starting at rr_ptr and grant the first one that presents a bit.
    always_comb begin
        int idx;
        grant_vec = '0;
        grant_idx = '0;
        accept    = 1'b0;
        idx       = 0;
        if (state_reg == RUN && !stall) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (int'(rr_ptr_reg) + k) % NCH;
                if (!accept && bus.ch_valid[idx]) begin
                    accept         = 1'b1;
                    grant_idx      = PW'(idx);
                    grant_vec[idx] = 1'b1;
                end
            end
        end
    end

    assign bus.ch_ready = grant_vec;
    assign grant_run    = run_next[grant_idx];
    // A bit taken while flush is high is thrown away, so it can never raise an event.
    assign fire         = accept & ~flush & (grant_run >= RUN_FIRE);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ctx
            assign run_next[gi] = !has_reg[gi]                   ? CW'(1) :
                                  (bus.ch_bit[gi] == last_reg[gi]) ? CW'(1) :
                                  (run_reg[gi] == RUN_MAX)        ? RUN_MAX :
                                                                    run_reg[gi] + CW'(1);

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    has_reg[gi]  <= 1'b0;
                    last_reg[gi] <= 1'b0;
                    run_reg[gi]  <= '0;
                end else if (grant_vec[gi]) begin
                    has_reg[gi]  <= 1'b1;
                    last_reg[gi] <= bus.ch_bit[gi];
                    run_reg[gi]  <= run_next[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!enable) state_next = DRAIN;
            DRAIN: begin
                if (enable)
                    state_next = RUN;
                else if (!det_valid_reg || bus.det_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            det_valid_reg <= 1'b0;
            det_ch_reg    <= '0;
            det_run_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept)
                rr_ptr_reg <= (grant_idx == LAST_CH) ? '0 : grant_idx + PW'(1);
            // While an event is held, accepts are blocked, so a new event can load only
            // when the slot is empty or is being consumed in this cycle.
            if (!det_valid_reg || bus.det_ready) begin
                det_valid_reg <= fire;
                if (fire) begin
                    det_ch_reg  <= grant_idx;
                    det_run_reg <= grant_run;
                end
            end
        end
    end

    assign bus.det_valid = det_valid_reg;
    assign bus.det_ch    = det_ch_reg;
    assign bus.det_run   = det_run_reg;
    assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_alt_run_scheduler.sv
// Directed checks for alt_run_scheduler (NCH=4, MIN_RUN=3, CW=4) with hand-computed expectations.
module tb_alt_run_scheduler;
    localparam int NCH     = 4;
    localparam int MIN_RUN = 3;
    localparam int CW      = 4;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic flush;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    alt_run_scheduler_if #(.NCH(NCH), .CW(CW)) ifc ();

    alt_run_scheduler #(.NCH(NCH), .MIN_RUN(MIN_RUN), .CW(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .flush  (flush),
        .busy   (busy),
        .bus    (ifc.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    always @(negedge clk)
        if (ifc.det_valid && ifc.det_ready)
            $display("event ch=%0d run=%0d t=%0t", ifc.det_ch, ifc.det_run, $time);

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        flush         = 1'b0;
        ifc.ch_valid  = '0;
        ifc.det_ready = 1'b1;
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    // Present one bit on channel ch for one cycle, then check the event that follows it.
    task automatic send(input int ch, input bit b, input bit exp_det, input int exp_run);
        ifc.ch_valid      = '0;
        ifc.ch_valid[ch]  = 1'b1;
        ifc.ch_bit        = '0;
        ifc.ch_bit[ch]    = b;
        ifc.det_ready     = 1'b1;
        #1;
        check($sformatf("grant_ch%0d", ch), ifc.ch_ready, 1 << ch);
        tick();
        ifc.ch_valid = '0;
        #1;
        check($sformatf("det_valid_ch%0d_b%0d", ch, b), ifc.det_valid, exp_det);
        if (exp_det) begin
            check("det_ch", ifc.det_ch, ch);
            check("det_run", ifc.det_run, exp_run);
        end
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        flush         = 1'b0;
        ifc.ch_valid  = '0;
        ifc.ch_bit    = '0;
        ifc.det_ready = 1'b1;
        tick();
        tick();
        check("rst_det_valid", ifc.det_valid, 0);
        check("rst_det_ch", ifc.det_ch, 0);
        check("rst_det_run", ifc.det_run, 0);
        check("rst_busy", busy, 0);
        check("rst_ch_ready", ifc.ch_ready, 0);
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        check("run_busy", busy, 1);

        // ch0 0,1,0,1,1: events at run 3 and 4, then the repeated bit restarts the run
        send(0, 1'b0, 1'b0, 0);
        send(0, 1'b1, 1'b0, 0);
        send(0, 1'b0, 1'b1, 3);
        send(0, 1'b1, 1'b1, 4);
        send(0, 1'b1, 1'b0, 0);

        // all channels requesting: one grant per cycle in rotation, wrapping 3->0
        do_reset();
        ifc.ch_valid = 4'hF;
        ifc.ch_bit   = 4'h0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_grant%0d", k), ifc.ch_ready, 1 << (k % 4));
            tick();
            check("rr_no_det", ifc.det_valid, 0);
        end
        ifc.ch_valid = '0;

        // ch2 alternating 20 bits: event from the 3rd bit onward, run saturates at 15
        do_reset();
        for (int k = 1; k <= 20; k++)
            send(2, 1'((k - 1) % 2), (k >= 3), (k > 15) ? 15 : k);

        // ch1 event held with det_ready=0 for 5 cycles
        do_reset();
        send(1, 1'b0, 1'b0, 0);
        send(1, 1'b1, 1'b0, 0);
        send(1, 1'b0, 1'b1, 3);
        ifc.det_ready = 1'b0;
        ifc.ch_valid  = 4'b0010;
        ifc.ch_bit    = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_det_valid", ifc.det_valid, 1);
            check("stall_det_ch", ifc.det_ch, 1);
            check("stall_det_run", ifc.det_run, 3);
            check("stall_ch_ready", ifc.ch_ready, 0);
            tick();
        end
        ifc.det_ready = 1'b1;
        #1;
        check("resume_grant", ifc.ch_ready, 4'b0010);
        tick();
        ifc.ch_valid = '0;
        #1;
        check("b2b_det_valid", ifc.det_valid, 1);
        check("b2b_det_ch", ifc.det_ch, 1);
        check("b2b_det_run", ifc.det_run, 4);
        tick();
        check("b2b_drained", ifc.det_valid, 0);

        // ch3 flush handling, then DRAIN with a pending event
        do_reset();
        send(3, 1'b1, 1'b0, 0);
        send(3, 1'b0, 1'b0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(3, 1'b1, 1'b0, 0);
        send(3, 1'b0, 1'b0, 0);
        ifc.ch_valid = 4'b1000;
        ifc.ch_bit   = 4'b1000;
        flush        = 1'b1;
        #1;
        check("flush_grant", ifc.ch_ready, 4'b1000);
        tick();
        flush        = 1'b0;
        ifc.ch_valid = '0;
        #1;
        check("flush_discard", ifc.det_valid, 0);
        send(3, 1'b0, 1'b0, 0);
        send(3, 1'b1, 1'b0, 0);
        send(3, 1'b0, 1'b1, 3);
        ifc.det_ready = 1'b0;
        enable        = 1'b0;
        ifc.ch_valid  = 4'b1000;
        ifc.ch_bit    = 4'b1000;
        tick();
        check("drain_busy", busy, 1);
        check("drain_ch_ready", ifc.ch_ready, 0);
        check("drain_det_valid", ifc.det_valid, 1);
        tick();
        check("drain_hold_busy", busy, 1);
        check("drain_hold_run", ifc.det_run, 3);
        ifc.det_ready = 1'b1;
        tick();
        ifc.ch_valid = '0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_det_valid", ifc.det_valid, 0);

        // reset mid-operation with an event pending and ch0 at run 2
        enable = 1'b1;
        tick();
        send(0, 1'b0, 1'b0, 0);
        send(0, 1'b1, 1'b0, 0);
        send(3, 1'b1, 1'b1, 4);
        ifc.det_ready = 1'b0;
        ifc.ch_valid  = 4'b0001;
        reset         = 1'b1;
        tick();
        check("mid_rst_det_valid", ifc.det_valid, 0);
        check("mid_rst_det_ch", ifc.det_ch, 0);
        check("mid_rst_det_run", ifc.det_run, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ch_ready", ifc.ch_ready, 0);
        reset        = 1'b0;
        enable       = 1'b1;
        ifc.ch_valid = '0;
        tick();
        send(0, 1'b0, 1'b0, 0);
        send(0, 1'b1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
